// File: rtl/flag_stack_register.sv
// ALU flag register (C, N, P, Z, V) with a LIFO of saved flag frames and misuse detection.
// Define FLAG_STACK_STICKY_ERR_EN to make err latch until reset instead of pulsing.
module flag_stack_register #(
  parameter int MAX_WIDTH   = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enaf,
  input  logic [MAX_WIDTH-1:0]             dataa,
  input  logic                             carry,
  input  logic                             ovf,
  input  logic                             push,
  input  logic                             pop,
  output logic                             C,
  output logic                             N,
  output logic                             P,
  output logic                             Z,
  output logic                             V,
  output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
  output logic                             full,
  output logic                             empty,
  output logic                             err
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SLOTS = 1 << IDX_W;

  function automatic logic even_parity(input logic [MAX_WIDTH-1:0] d);
    return ~^d;
  endfunction

  function automatic logic is_zero(input logic [MAX_WIDTH-1:0] d);
    return (d == '0);
  endfunction

  // Frame layout {V,C,N,P,Z}; slots beyond STACK_DEPTH are never addressed.
  logic [4:0]       stack [SLOTS];
  logic [4:0]       load_frame;
  logic [4:0]       cur_frame;
  logic [SP_W-1:0]  sp_m1;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             push_ok;
  logic             pop_ok;
  logic             misuse;

  assign full  = (sp == SP_W'(STACK_DEPTH));
  assign empty = (sp == '0);

  assign push_ok = push & ~pop & ~full;
  assign pop_ok  = pop & ~push & ~empty;
  assign misuse  = (push & full) | (pop & empty) | (push & pop);

  assign sp_m1  = sp - SP_W'(1);
  assign wr_idx = sp[IDX_W-1:0];
  assign rd_idx = sp_m1[IDX_W-1:0];

  assign load_frame = {ovf, carry, dataa[MAX_WIDTH-1], even_parity(dataa), is_zero(dataa)};
  assign cur_frame  = {V, C, N, P, Z};

  // Storage holds no reset; an empty stack is never read.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      stack[wr_idx] <= cur_frame;
    end
  end

  // Flag, pointer and error state; a restore beats a fresh flag load.
  always_ff @(posedge clk) begin
    if (rst) begin
      {V, C, N, P, Z} <= 5'b0;
      sp              <= '0;
      err             <= 1'b0;
    end else begin
      if (pop_ok) begin
        {V, C, N, P, Z} <= stack[rd_idx];
      end else if (enaf) begin
        {V, C, N, P, Z} <= load_frame;
      end

      if (push_ok) begin
        sp <= sp + SP_W'(1);
      end else if (pop_ok) begin
        sp <= sp_m1;
      end

`ifdef FLAG_STACK_STICKY_ERR_EN
      err <= err | misuse;
`else
      err <= misuse;
`endif
    end
  end

endmodule

// File: doc/flag_stack_register.md
FLAG_STACK_REGISTER -- requirements
Module: flag_stack_register

Interface
REQ-001 The block SHALL have parameter MAX_WIDTH, default 8, the data word width (legal range >= 2).
REQ-002 The block SHALL have parameter STACK_DEPTH, default 4, the number of saved flag frames (legal range >= 1).
REQ-003 clk  input  1  Single clock; all state updates on its rising edge.
REQ-004 rst  input  1  Reset; synchronous and active-high.
REQ-005 enaf  input  1  Flag update enable.
REQ-006 dataa  input  MAX_WIDTH  ALU result word used to derive the N, P and Z flags.
REQ-007 carry  input  1  Carry-out source for C.
REQ-008 ovf  input  1  Signed-overflow source for V.
REQ-009 push  input  1  Save the current flag frame {V,C,N,P,Z} onto the stack.
REQ-010 pop  input  1  Restore the flag frame from the top of the stack.
REQ-011 C, N, P, Z, V  output  1 each  Registered flags.
REQ-012 sp  output  $clog2(STACK_DEPTH+1)  Number of valid frames on the stack.
REQ-013 full, empty  output  1 each  Stack status; combinational from sp.
REQ-014 err  output  1  Stack misuse indication.

Function
REQ-015 When enaf=1 and no pop is accepted, the block SHALL load the flags on the next clock edge, visible one cycle after the inputs are presented:
- C<=carry
- V<=ovf
- N<=dataa[MAX_WIDTH-1]
- P<= 1 when dataa has an even number of ones across all MAX_WIDTH bits
- Z<= 1 when dataa==0
REQ-016 When enaf=0 and no pop is accepted, the block SHALL hold all flags.
REQ-017 A push with full=0 and pop=0 SHALL write the pre-edge flag values to stack[sp] and increment sp.
REQ-018 A pop with empty=0 and push=0 SHALL load the flags from stack[sp-1] and decrement sp.
REQ-019 An accepted pop SHALL take priority over enaf, and the enaf update SHALL be discarded that cycle.
REQ-020 When push and enaf are asserted in the same cycle, the block SHALL save the old flags and load the new flags in the same edge.
REQ-021 The error conditions SHALL be:
- push with full=1
- pop with empty=1
- push and pop together
REQ-022 On an error condition, the block SHALL leave sp and the stack contents unchanged, SHALL still apply enaf, and SHALL raise the err event.
REQ-023 The block SHALL drive full=1 when sp==STACK_DEPTH and empty=1 when sp==0.
REQ-024 sp SHALL never wrap: it SHALL saturate at 0 and at STACK_DEPTH.

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL set C, N, P, Z, V and err to 0 and sp to 0 (empty=1, full=0); this SHALL override push, pop and enaf.
REQ-026 Stack storage contents need not be cleared on reset, and an empty stack SHALL never be read.
REQ-027 A reset asserted mid-sequence SHALL discard all saved frames, and the first pop after reset SHALL be an error.

Configuration
REQ-028 The block SHALL support the macro FLAG_STACK_STICKY_ERR_EN.
REQ-029 When FLAG_STACK_STICKY_ERR_EN is defined, err SHALL go high on the cycle after the first error and stay high until rst.
REQ-030 When FLAG_STACK_STICKY_ERR_EN is not defined, err SHALL be a registered one-cycle pulse on the cycle after each error.

Verification
REQ-031 The bench SHALL cover: rst, then enaf=1 with dataa=8'h00 and carry=1 -> next cycle Z=1, P=1, N=0, C=1, V=0.
REQ-032 The bench SHALL cover: enaf=1 with dataa=8'h83 and ovf=1 -> N=1, P=0, Z=0, V=1; repeat with MAX_WIDTH=12 and dataa=12'h801 -> N=1, P=1.
REQ-033 The bench SHALL cover: four pushes of distinct frames (STACK_DEPTH=4) -> sp=4, full=1; a fifth push -> err asserted and sp stays 4; four pops -> frames restored in LIFO order and empty=1.
REQ-034 The bench SHALL cover: push with enaf=1 and dataa=0 while Z=0 -> Z=1 now; a following pop -> Z=0 restored.
REQ-035 The bench SHALL cover: pop with enaf=1 on a non-empty stack -> restored frame wins and enaf is ignored; pop on an empty stack -> err, flags follow enaf.
REQ-036 The bench SHALL cover: push and pop together, then rst after two pushes -> err asserted, then after reset sp=0 and all flags 0; the err duration SHALL be checked both with and without FLAG_STACK_STICKY_ERR_EN.
